// File: rtl/uart_in_feeder_if.sv
// Purpose: host-side push handshake plus the SimTop UART input request/response pair.
// Latency: pure wiring, no state.
// Backpressure: host_ready gates host_valid; uart_in_valid is never stalled.
//
// Signals:
//   host_valid / host_ch / host_ready : character offered by the host, accepted on valid && ready
//   uart_in_valid / uart_in_ch        : SimTop byte request and the byte returned in the same cycle
interface uart_in_feeder_if;
  logic       host_valid;
  logic [7:0] host_ch;
  logic       host_ready;
  logic       uart_in_valid;
  logic [7:0] uart_in_ch;

  // master: host poller + SimTop side; slave: the feeder
  modport master (
    output host_valid,
    output host_ch,
    output uart_in_valid,
    input  host_ready,
    input  uart_in_ch
  );

  modport slave (
    input  host_valid,
    input  host_ch,
    input  uart_in_valid,
    output host_ready,
    output uart_in_ch
  );
endinterface

// File: rtl/uart_in_feeder.sv
// Purpose: answers each SimTop UART input request with the next host-queued byte, or 0xFF if none.
// Latency: uart_in_ch is combinational from registered state (zero-cycle answer); a pushed byte is visible next cycle.
// Backpressure: host_ready drops while the FIFO is full; requests are never stalled, only starved with 0xFF.
//
// Ports:
//   clock, reset (async, active-low)
//   bus           : uart_in_feeder_if.slave (host push handshake, UART request/response)
//   fifo_count    : current occupancy, 0..DEPTH
//   served_count  : saturating count of requests answered with queued data
//   starved_count : saturating count of requests answered with 0xFF
module uart_in_feeder #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  uart_in_feeder_if.slave          bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         served_count,
  output logic [CNT_W-1:0]         starved_count
);

  localparam int AW = $clog2(DEPTH);
  // gap counter only needs to hold GAP_CYCLES; keep at least one bit when pacing is off
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [GW-1:0] gap_cnt;

  logic full;
  logic avail;
  logic pop;
  logic starve;
  logic push;

  // Full/empty come from the registered occupancy, so a pop in the same
  // cycle never frees a slot for a push while full.
  assign full  = (fifo_count == DEPTH_C);
  assign avail = (fifo_count != '0) && (gap_cnt == '0);

  assign pop    = bus.uart_in_valid && avail;
  assign starve = bus.uart_in_valid && !avail;
  assign push   = bus.host_valid && !full;

  assign bus.host_ready = !full;

  // Answer is independent of uart_in_valid; no write-through bypass, so a
  // byte pushed into an empty FIFO appears only after the edge.
  always_comb begin
    bus.uart_in_ch = 8'hFF;
    if (avail) begin
      bus.uart_in_ch = mem[rd_ptr];
    end
  end

  // Storage carries no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.host_ch;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A pop reloads the gap; otherwise it drains to zero. With G loaded, the
  // next pop lands G+1 cycles after the previous one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap_cnt <= '0;
    end else if (pop) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Statistics hold at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      served_count  <= '0;
      starved_count <= '0;
    end else begin
      if (pop && (served_count != '1)) begin
        served_count <= served_count + 1'b1;
      end
      if (starve && (starved_count != '1)) begin
        starved_count <= starved_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_in_feeder.sv
module tb_uart_in_feeder;

  // Two instances: default-sized unpaced FIFO, and a small paced FIFO with narrow counters
  localparam int D0 = 16;
  localparam int G0 = 0;
  localparam int W0 = 32;
  localparam int D1 = 4;
  localparam int G1 = 3;
  localparam int W1 = 4;
  localparam int HN = 8192;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_in_feeder_if if0 ();
  uart_in_feeder_if if1 ();

  logic [4:0]  fc0;
  logic [31:0] sv0;
  logic [31:0] st0;
  logic [2:0]  fc1;
  logic [3:0]  sv1;
  logic [3:0]  st1;

  uart_in_feeder #(.DEPTH(D0), .GAP_CYCLES(G0), .CNT_W(W0)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave),
    .fifo_count(fc0), .served_count(sv0), .starved_count(st0)
  );

  uart_in_feeder #(.DEPTH(D1), .GAP_CYCLES(G1), .CNT_W(W1)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave),
    .fifo_count(fc1), .served_count(sv1), .starved_count(st1)
  );

  // stimulus per instance
  logic       hv [2];
  logic [7:0] hc [2];
  logic       uv [2];

  assign if0.host_valid    = hv[0];
  assign if0.host_ch       = hc[0];
  assign if0.uart_in_valid = uv[0];
  assign if1.host_valid    = hv[1];
  assign if1.host_ch       = hc[1];
  assign if1.uart_in_valid = uv[1];

  // observed outputs, zero-extended to common widths
  logic [7:0]  ch_o  [2];
  logic        rdy_o [2];
  logic [7:0]  cnt_o [2];
  logic [31:0] srv_o [2];
  logic [31:0] stv_o [2];

  assign ch_o[0]  = if0.uart_in_ch;
  assign ch_o[1]  = if1.uart_in_ch;
  assign rdy_o[0] = if0.host_ready;
  assign rdy_o[1] = if1.host_ready;
  assign cnt_o[0] = 8'(fc0);
  assign cnt_o[1] = 8'(fc1);
  assign srv_o[0] = sv0;
  assign srv_o[1] = 32'(sv1);
  assign stv_o[0] = st0;
  assign stv_o[1] = 32'(st1);

  // Reference model: every accepted byte is appended to a history; the
  // occupancy is pushes minus pops, the head is history[pops]. Pacing is
  // expressed as "at least G+1 cycles since the last delivered byte".
  int         dep  [2];
  int         gap  [2];
  longint     cmax [2];
  logic [7:0] hist [2][HN];
  int         wr_n [2];
  int         rd_n [2];
  int         last_pop [2];
  longint     m_srv [2];
  longint     m_stv [2];
  int         cyc;
  logic       acc [2];
  logic [7:0] obs [2];

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_occ(input int d);
    return wr_n[d] - rd_n[d];
  endfunction

  function automatic logic m_avail(input int d);
    return (m_occ(d) > 0) && ((cyc - last_pop[d]) > gap[d]);
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      wr_n[d]     = 0;
      rd_n[d]     = 0;
      last_pop[d] = -100;
      m_srv[d]    = 0;
      m_stv[d]    = 0;
    end
  endtask

  // One clock cycle: compare all outputs against the model mid-cycle, then
  // advance the model by what the current inputs do at the rising edge.
  task automatic cycle();
    logic p_pop [2];
    logic p_push [2];
    logic p_stv [2];
    logic [7:0] exp_ch;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      exp_ch = m_avail(d) ? hist[d][rd_n[d] % HN] : 8'hFF;
      check($sformatf("ch%0d", d), 64'(ch_o[d]), 64'(exp_ch));
      check($sformatf("ready%0d", d), 64'(rdy_o[d]), 64'(m_occ(d) < dep[d]));
      check($sformatf("count%0d", d), 64'(cnt_o[d]), 64'(m_occ(d)));
      check($sformatf("served%0d", d), 64'(srv_o[d]), 64'(m_srv[d]));
      check($sformatf("starved%0d", d), 64'(stv_o[d]), 64'(m_stv[d]));
      obs[d]    = ch_o[d];
      p_pop[d]  = reset && uv[d] && m_avail(d);
      p_stv[d]  = reset && uv[d] && !m_avail(d);
      p_push[d] = reset && hv[d] && (m_occ(d) < dep[d]);
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (p_push[d]) begin
        hist[d][wr_n[d] % HN] = hc[d];
        wr_n[d]++;
      end
      if (p_pop[d]) begin
        rd_n[d]++;
        last_pop[d] = cyc;
        if (m_srv[d] < cmax[d]) m_srv[d]++;
      end
      if (p_stv[d] && (m_stv[d] < cmax[d])) m_stv[d]++;
      acc[d] = p_push[d];
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      hv[d] = 1'b0;
      uv[d] = 1'b0;
    end
  endtask

  logic [7:0] exp_abc [4];
  logic [7:0] exp_gap [6];
  logic [31:0] st_base;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    dep[0] = D0;  dep[1] = D1;
    gap[0] = G0;  gap[1] = G1;
    cmax[0] = 64'hFFFF_FFFF;
    cmax[1] = 15;
    exp_abc = '{8'h41, 8'h42, 8'h43, 8'hFF};
    exp_gap = '{8'h31, 8'hFF, 8'hFF, 8'hFF, 8'h32, 8'hFF};
    for (int d = 0; d < 2; d++) begin
      hc[d]  = 8'h00;
      acc[d] = 1'b0;
      obs[d] = 8'h00;
    end
    idle();
    m_reset();

    // Requests during reset are ignored
    reset = 1'b0;
    uv[0] = 1'b1;
    uv[1] = 1'b1;
    repeat (3) cycle();
    reset = 1'b1;

    // Empty FIFO: three starved requests
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("empty_ch", 64'(obs[0]), 64'hFF);
    end
    check("empty_starved", 64'(st0), 64'd3);
    check("empty_served", 64'(sv0), 64'd0);
    idle();

    // 'A','B','C' then four requests
    for (int i = 0; i < 3; i++) begin
      hv[0] = 1'b1;
      hc[0] = 8'h41 + 8'(i);
      cycle();
    end
    idle();
    uv[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("abc_ch", 64'(obs[0]), 64'(exp_abc[i]));
    end
    idle();
    check("abc_served", 64'(sv0), 64'd3);
    check("abc_starved", 64'(st0), 64'd4);
    check("abc_count", 64'(fc0), 64'd0);

    // Fill to 16, hold a 17th, pop once, 17th enters afterwards
    hv[0] = 1'b1;
    for (int i = 0; i < D0; i++) begin
      hc[0] = 8'($urandom);
      cycle();
    end
    check("full_ready", 64'(rdy_o[0]), 64'd0);
    check("full_count", 64'(fc0), 64'd16);
    hc[0] = 8'hAA;
    cycle();
    check("full_refuse", 64'(fc0), 64'd16);
    uv[0] = 1'b1;
    cycle();
    check("full_pop_no_push", 64'(fc0), 64'd15);
    uv[0] = 1'b0;
    cycle();
    check("full_accept", 64'(fc0), 64'd16);
    hv[0] = 1'b0;
    uv[0] = 1'b1;
    repeat (D0) cycle();
    check("full_last", 64'(obs[0]), 64'hAA);
    check("full_drained", 64'(fc0), 64'd0);
    idle();

    // Simultaneous push and pop at occupancy 5
    for (int i = 0; i < 5; i++) begin
      hv[0] = 1'b1;
      hc[0] = 8'h50 + 8'(i);
      cycle();
    end
    hc[0] = 8'h77;
    uv[0] = 1'b1;
    cycle();
    check("pp_head", 64'(obs[0]), 64'h50);
    check("pp_count", 64'(fc0), 64'd5);
    hv[0] = 1'b0;
    repeat (5) cycle();
    check("pp_last", 64'(obs[0]), 64'h77);
    idle();

    // Pacing on the G=3 instance
    for (int i = 0; i < 2; i++) begin
      hv[1] = 1'b1;
      hc[1] = 8'h31 + 8'(i);
      cycle();
    end
    idle();
    st_base = stv_o[1];
    uv[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("gap_ch", 64'(obs[1]), 64'(exp_gap[i]));
      if (i == 4) check("gap_starved", 64'(stv_o[1] - st_base), 64'd3);
    end
    idle();

    // Randomised traffic: first host-heavy, then request-heavy
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!hv[d] || acc[d]) begin
          hv[d] = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
          hc[d] = 8'($urandom);
        end
        uv[d] = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      end
      cycle();
    end
    idle();

    // Asynchronous reset mid-operation with queued bytes
    for (int i = 0; i < 4; i++) begin
      hv[0] = 1'b1;
      hv[1] = 1'b1;
      hc[0] = 8'($urandom);
      hc[1] = 8'($urandom);
      cycle();
    end
    idle();
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("arst_count", 64'(cnt_o[d]), 64'd0);
      check("arst_ready", 64'(rdy_o[d]), 64'd1);
      check("arst_ch", 64'(ch_o[d]), 64'hFF);
      check("arst_served", 64'(srv_o[d]), 64'd0);
      check("arst_starved", 64'(stv_o[d]), 64'd0);
    end
    m_reset();
    uv[0] = 1'b1;
    uv[1] = 1'b1;
    repeat (2) cycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("post_rst_ch0", 64'(obs[0]), 64'hFF);
      check("post_rst_ch1", 64'(obs[1]), 64'hFF);
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_in_feeder.md
Name: uart_in_feeder

Overview:
- Responder for the simulated UART input channel of SimTop: answers each io_uart_in_valid request with one byte from a host-filled FIFO, or 0xFF when none is available.
- Sits in the simulation top beside the UART output printer. It replaces the constant 0xFF tie-off on the input channel.
- Host side (DPI poller or bench) pushes characters through a valid/ready handshake.
- Optional pacing gap emulates baud-rate spacing between delivered characters.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 2.
- GAP_CYCLES, 0: minimum cycles after a delivered byte before the next byte may be delivered; 0 disables pacing.
- CNT_W, 32: width of the statistics counters.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = in reset).
- host_valid  input  1  host offers host_ch.
- host_ch  input  8  character to enqueue.
- host_ready  output  1  FIFO can accept this cycle.
- uart_in_valid  input  1  SimTop requests one byte this cycle (io_uart_in_valid).
- uart_in_ch  output  8  byte returned in the same cycle (drives io_uart_in_ch).
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- served_count  output  CNT_W  requests answered with FIFO data.
- starved_count  output  CNT_W  requests answered with 0xFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; read and write pointers 0.
  - gap_cnt=0; both counters 0.
  - Outputs: fifo_count=0, host_ready=1, uart_in_ch=0xFF.
- Availability: avail = (fifo_count != 0) && (gap_cnt == 0).
- uart_in_ch is combinational, with zero latency:
  - head entry when avail;
  - 0xFF otherwise;
  - independent of uart_in_valid.
- Pop: uart_in_valid && avail.
  - Read pointer advances at the edge.
  - served_count += 1, saturating at all-ones.
  - gap_cnt loads GAP_CYCLES.
- Starve: uart_in_valid && !avail.
  - No FIFO change.
  - starved_count += 1, saturating.
- Gap counter: when nonzero and no pop occurs, decrements by 1 per cycle. With GAP_CYCLES=G, the earliest next pop is G+1 cycles after the previous pop.
- Push: host_valid && host_ready.
  - Writes host_ch at the write pointer; pointer advances.
  - host_ready = (fifo_count < DEPTH), registered-state based. While full, push is refused even if a pop occurs in the same cycle.
  - Host must hold host_valid/host_ch stable until accepted; no data is ever dropped.
- Simultaneous push and pop (not full): both occur, fifo_count unchanged, and the popped byte is the old head.
- Push into an empty FIFO: the byte becomes visible on uart_in_ch the next cycle, not the same cycle. There is no bypass.
- Pointers: $clog2(DEPTH) bits with natural wrap-around. Full/empty are derived from fifo_count.
- uart_in_valid asserted during reset: ignored; counters stay 0.
- Reset asserted mid-operation: all queued bytes are discarded, the gap is cleared, and the state above is restored immediately, without waiting for a clock edge.

Test Plan:
- Reset, then uart_in_valid=1 for 3 cycles with an empty FIFO -> uart_in_ch=0xFF each cycle, starved_count=3, served_count=0.
- Push 'A','B','C' (0x41,0x42,0x43), GAP_CYCLES=0, then request 4 consecutive cycles -> 0x41,0x42,0x43,0xFF; served_count=3, starved_count=1, fifo_count=0.
- DEPTH=16: push 16 bytes -> host_ready=0 at fifo_count=16. Hold a 17th byte with host_valid=1 and pop once -> the 17th is accepted the cycle after the pop, with no byte lost or duplicated.
- FIFO at count 5: push and pop in the same cycle -> fifo_count stays 5, popped byte is the old head, pushed byte is delivered last.
- GAP_CYCLES=3: queue 0x31,0x32 and request every cycle -> 0x31 at cycle t, 0xFF at t+1..t+3, 0x32 at t+4; starved_count=3.
- Queue 4 bytes, assert reset=0 between clock edges -> fifo_count=0, host_ready=1, uart_in_ch=0xFF immediately; after release, requests return 0xFF.
